doodle_jump_fsm: RTL

Game-flow state machine for the doodle player; sits directly upstream of the VGA controller. It drives the one-hot `q_I`/`q_Up`/`q_Down`/`q_Done` state outputs that the controller uses to move and paint the doodle. It closes the loop on the controller's `xpos`, `ypos` and `up_count` outputs. It performs platform landing detection, apex detection and fall-off detection, and keeps the landing score.

---
 rtl/doodle_jump_fsm.sv | 129 ++++++++++++
 1 files changed

// File: rtl/doodle_jump_fsm.sv
// Game-flow FSM for the doodle: INIT/UP/DOWN/DONE with platform landing,
// apex and fall-off detection, plus a saturating landing score.
module doodle_jump_fsm #(
  parameter int unsigned RADIUS       = 10,
  parameter int unsigned JUMP_HEIGHT  = 120,
  parameter int unsigned TOP_LIMIT    = 45,
  parameter int unsigned BOTTOM_LIMIT = 515,
  parameter int unsigned PLAT_W       = 64,
  parameter int unsigned LAND_TOL     = 3,
  parameter int unsigned P0_X         = 256,
  parameter int unsigned P0_Y         = 470,
  parameter int unsigned P1_X         = 374,
  parameter int unsigned P1_Y         = 490,
  parameter int unsigned P2_X         = 600,
  parameter int unsigned P2_Y         = 330,
  parameter int unsigned P3_X         = 300,
  parameter int unsigned P3_Y         = 300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [9:0] xpos,
  input  logic [9:0] ypos,
  input  logic [7:0] up_count,
  input  logic [9:0] v_offset,
  output logic       q_I,
  output logic       q_Up,
  output logic       q_Down,
  output logic       q_Done,
  output logic       landed,
  output logic [7:0] score
);

  typedef enum logic [1:0] {INIT, UP, DOWN, DONE} state_t;

  localparam logic [10:0] RAD11    = 11'(RADIUS);
  localparam logic [10:0] JUMP11   = 11'(JUMP_HEIGHT);
  localparam logic [10:0] TOP11    = 11'(TOP_LIMIT);
  localparam logic [10:0] BOTTOM11 = 11'(BOTTOM_LIMIT);
  localparam logic [10:0] PW11     = 11'(PLAT_W);
  localparam logic [10:0] TOL11    = 11'(LAND_TOL);

  state_t      state_q, state_d;
  logic        start_q;
  logic        start_edge;
  logic [10:0] xe, ye, ue, vo;
  logic [10:0] x_left, x_right, bottom;
  logic [10:0] top0, top1, top2, top3;
  logic        hit0, hit1, hit2, hit3;
  logic        land, fall;

  function automatic logic plat_hit(input logic [10:0] left, input logic [10:0] right,
                                    input logic [10:0] bot, input logic [10:0] px,
                                    input logic [10:0] top);
    plat_hit = (right >= px) && (left <= px + PW11) &&
               (bot >= top) && (bot <= top + TOL11);
  endfunction

  assign start_edge = start & ~start_q;

  assign xe = {1'b0, xpos};
  assign ye = {1'b0, ypos};
  assign ue = {3'b000, up_count};
  assign vo = {1'b0, v_offset};

  assign x_right = xe + RAD11;
  assign x_left  = (xe < RAD11) ? '0 : xe - RAD11;
  assign bottom  = ye + RAD11;

  // Ground platform is fixed; the others move with the scroll offset.
  assign top0 = 11'(P0_Y);
  assign top1 = 11'(P1_Y) + vo;
  assign top2 = 11'(P2_Y) + vo;
  assign top3 = 11'(P3_Y) + vo;

  assign hit0 = plat_hit(x_left, x_right, bottom, 11'(P0_X), top0);
  assign hit1 = plat_hit(x_left, x_right, bottom, 11'(P1_X), top1);
  assign hit2 = plat_hit(x_left, x_right, bottom, 11'(P2_X), top2);
  assign hit3 = plat_hit(x_left, x_right, bottom, 11'(P3_X), top3);

  assign land = (state_q == DOWN) && (hit0 || hit1 || hit2 || hit3);
  assign fall = (state_q == DOWN) && (bottom >= BOTTOM11);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT: if (start_edge) state_d = UP;
      UP:   if ((ue >= JUMP11) || (ye <= TOP11)) state_d = DOWN;
      DOWN: begin
        // Landing wins over fall-off when both hold in the same cycle.
        if (land)      state_d = UP;
        else if (fall) state_d = DONE;
      end
      DONE: if (start_edge) state_d = INIT;
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    q_I    = (state_q == INIT);
    q_Up   = (state_q == UP);
    q_Down = (state_q == DOWN);
    q_Done = (state_q == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      landed <= 1'b0;
      score  <= '0;
    end else begin
      landed <= land;
      if ((state_q == INIT) && start_edge)
        score <= '0;
      else if (land && (score != '1))
        score <= score + 8'd1;
    end
  end

endmodule
